// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM configuration front-end.
//   CNT_W      : width of period and threshold counts
//   DUTY_W     : width of the permille duty request
//   DUTY_SCALE : full-scale duty value (permille)
//   PROD_W     : width of the period * duty product
//   state_t    : sequencing states of pwm_param_calc
package pwm_pkg;

    localparam int unsigned CNT_W      = 28;
    localparam int unsigned DUTY_W     = 10;
    localparam int unsigned DUTY_SCALE = 1000;
    localparam int unsigned PROD_W     = CNT_W + DUTY_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_div_seq.sv
// Sequential restoring divider by a constant divisor, one quotient bit per
// cycle, MSB first.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a division (dividend must stay stable while busy)
//   dividend  : DIVIDEND_W-bit numerator
//   quotient  : QUOTIENT_W-bit truncated quotient, final after done_c's edge
//   done_c    : high during the cycle whose edge performs the last iteration
module pwm_div_seq #(
    parameter int unsigned DIVIDEND_W = 38,
    parameter int unsigned QUOTIENT_W = 38,
    parameter int unsigned DIVISOR    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic                  done_c
);

    // Remainder stays below DIVISOR; one extra bit holds the shifted value.
    localparam int unsigned REM_W  = $clog2(DIVISOR) + 1;
    localparam int unsigned ITER_W = $clog2(DIVIDEND_W);

    logic              busy;
    logic [ITER_W-1:0] iter;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  rem_sh;
    logic [REM_W-1:0]  rem_nx;
    logic [ITER_W-1:0] bit_idx;
    logic              fits;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        bit_idx = ITER_W'(DIVIDEND_W - 1) - iter;
        rem_sh  = (rem << 1) | REM_W'(dividend[bit_idx]);
        fits    = (rem_sh >= REM_W'(DIVISOR));
        rem_nx  = fits ? (rem_sh - REM_W'(DIVISOR)) : rem_sh;
        done_c  = busy && (iter == ITER_W'(DIVIDEND_W - 1));
    end

    // Iteration state; the counter saturates at its terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            iter     <= '0;
            rem      <= '0;
            quotient <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            iter     <= '0;
            rem      <= '0;
            quotient <= '0;
        end else if (busy) begin
            rem      <= rem_nx;
            quotient <= (quotient << 1) | QUOTIENT_W'(fits);
            if (done_c) begin
                busy <= 1'b0;
            end else begin
                iter <= iter + ITER_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_param_calc.sv
// PWM configuration front-end: turns a period / permille duty request into
// the controller's period and high-time thresholds.
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_vld/cfg_rdy : request handshake (accepted when both high)
//   cfg_period      : requested period N in clk cycles
//   cfg_duty        : requested duty D in permille (clamped to full scale)
//   cfg_err         : one-cycle pulse when a request with N < 2 is rejected
//   para_config_vld : one-cycle strobe when new thresholds are loaded
//   period_limit    : N-1
//   high_limit      : floor(N * min(D, DUTY_SCALE) / DUTY_SCALE)
module pwm_param_calc
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_vld,
    output logic              cfg_rdy,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              cfg_err,
    output logic              para_config_vld,
    output logic [CNT_W-1:0]  period_limit,
    output logic [CNT_W-1:0]  high_limit
);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cap_n;
    logic [DUTY_W-1:0]   cap_d;
    logic [PROD_W-1:0]   prod;
    logic [CNT_W-1:0]    quotient;
    logic                div_done_c;
    logic                start_c;
    logic                capture_c;
    logic [DUTY_W-1:0]   duty_clamp_c;
    logic                rdy_nx;
    logic                err_nx;
    logic                vld_nx;
    logic [CNT_W-1:0]    period_nx;
    logic [CNT_W-1:0]    high_nx;

    // Duty above full scale saturates silently.
    always_comb begin
        duty_clamp_c = (cfg_duty > DUTY_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE) : cfg_duty;
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nx  = state;
        err_nx    = 1'b0;
        vld_nx    = 1'b0;
        period_nx = period_limit;
        high_nx   = high_limit;
        start_c   = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_vld && cfg_rdy) begin
                    if (cfg_period < CNT_W'(2)) begin
                        err_nx = 1'b1;
                    end else begin
                        capture_c = 1'b1;
                        state_nx  = MUL;
                    end
                end
            end
            MUL: begin
                start_c  = 1'b1;
                state_nx = DIV;
            end
            DIV: begin
                if (div_done_c) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                period_nx = cap_n - CNT_W'(1);
                high_nx   = quotient;
                vld_nx    = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        rdy_nx = (state_nx == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cfg_rdy         <= 1'b1;
            cfg_err         <= 1'b0;
            para_config_vld <= 1'b0;
            period_limit    <= '0;
            high_limit      <= '0;
        end else begin
            state           <= state_nx;
            cfg_rdy         <= rdy_nx;
            cfg_err         <= err_nx;
            para_config_vld <= vld_nx;
            period_limit    <= period_nx;
            high_limit      <= high_nx;
        end
    end

    // Request capture and product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_n <= '0;
            cap_d <= '0;
            prod  <= '0;
        end else begin
            if (capture_c) begin
                cap_n <= cfg_period;
                cap_d <= duty_clamp_c;
            end
            if (state == MUL) begin
                prod <= PROD_W'(cap_n) * PROD_W'(cap_d);
            end
        end
    end

    // Quotient never exceeds N, so only CNT_W quotient bits are kept.
    pwm_div_seq #(
        .DIVIDEND_W (PROD_W),
        .QUOTIENT_W (CNT_W),
        .DIVISOR    (DUTY_SCALE)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
        .dividend (prod),
        .quotient (quotient),
        .done_c   (div_done_c)
    );

endmodule

// File: tb/tb_pwm_param_calc.sv
// Directed self-checking bench for pwm_param_calc.
module tb_pwm_param_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_vld;
    logic        cfg_rdy;
    logic [27:0] cfg_period;
    logic [9:0]  cfg_duty;
    logic        cfg_err;
    logic        para_config_vld;
    logic [27:0] period_limit;
    logic [27:0] high_limit;

    int checks   = 0;
    int failures = 0;

    pwm_param_calc dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_vld         (cfg_vld),
        .cfg_rdy         (cfg_rdy),
        .cfg_period      (cfg_period),
        .cfg_duty        (cfg_duty),
        .cfg_err         (cfg_err),
        .para_config_vld (para_config_vld),
        .period_limit    (period_limit),
        .high_limit      (high_limit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request (called #1 after an edge, DUT idle) and observes
    // 45 following edges. lat = edge index of the first strobe, -1 if none.
    task automatic do_request(input logic [27:0] n, input logic [9:0] d,
                              output int lat, output logic [27:0] pl, output logic [27:0] hl,
                              output int vld_cnt, output int err_cnt,
                              output int early_chg, output int rdy_low);
        logic [27:0] pl0;
        logic [27:0] hl0;
        pl0 = period_limit;
        hl0 = high_limit;
        lat = -1; pl = '0; hl = '0;
        vld_cnt = 0; err_cnt = 0; early_chg = 0; rdy_low = 0;
        cfg_period = n;
        cfg_duty   = d;
        cfg_vld    = 1'b1;
        @(posedge clk); #1;
        cfg_vld = 1'b0;
        if (cfg_err) err_cnt++;
        if (!cfg_rdy) rdy_low++;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (cfg_err) err_cnt++;
            if (!cfg_rdy) rdy_low++;
            if (para_config_vld) begin
                vld_cnt++;
                if (lat < 0) begin
                    lat = i; pl = period_limit; hl = high_limit;
                end
            end else if (lat < 0 && (period_limit !== pl0 || high_limit !== hl0)) begin
                early_chg++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_vld = 1'b0; cfg_period = '0; cfg_duty = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", cfg_rdy); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
        checks++; if (para_config_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", para_config_vld); end
        checks++; if (period_limit !== 28'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_limit); end
        checks++; if (high_limit !== 28'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", high_limit); end
        rst = 1'b0;
    endtask

    // Normal requests: latency, values, single strobe, hold and rdy timing.
    task automatic test_compute;
        logic [27:0] vn [5] = '{28'd1000, 28'd3, 28'h0FFFFFFF, 28'd100, 28'd100};
        logic [9:0]  vd [5] = '{10'd250, 10'd500, 10'd1000, 10'd0, 10'd1023};
        logic [27:0] ep [5] = '{28'd999, 28'd2, 28'h0FFFFFFE, 28'd99, 28'd99};
        logic [27:0] eh [5] = '{28'd250, 28'd1, 28'h0FFFFFFF, 28'd0, 28'd100};
        int lat, vc, ec, ch, rl;
        logic [27:0] pl, hl;
        for (int t = 0; t < 5; t++) begin
            do_request(vn[t], vd[t], lat, pl, hl, vc, ec, ch, rl);
            checks++; if (lat != 40) begin failures++; $display("FAIL lat_%0d got=%0d exp=40", t, lat); end
            checks++; if (pl !== ep[t]) begin failures++; $display("FAIL period_%0d got=%0d exp=%0d", t, pl, ep[t]); end
            checks++; if (hl !== eh[t]) begin failures++; $display("FAIL high_%0d got=%0d exp=%0d", t, hl, eh[t]); end
            checks++; if (vc != 1) begin failures++; $display("FAIL vld_count_%0d got=%0d exp=1", t, vc); end
            checks++; if (ec != 0) begin failures++; $display("FAIL no_err_%0d got=%0d exp=0", t, ec); end
            checks++; if (ch != 0) begin failures++; $display("FAIL early_change_%0d got=%0d exp=0", t, ch); end
            checks++; if (rl != 40) begin failures++; $display("FAIL rdy_low_cycles_%0d got=%0d exp=40", t, rl); end
        end
    endtask

    // N < 2 is rejected; previous outputs (99/100) must be retained.
    task automatic test_reject;
        logic [27:0] vn [2] = '{28'd1, 28'd0};
        int lat, vc, ec, ch, rl;
        logic [27:0] pl, hl;
        for (int t = 0; t < 2; t++) begin
            cfg_period = vn[t]; cfg_duty = 10'd500; cfg_vld = 1'b1;
            @(posedge clk); #1;
            cfg_vld = 1'b0;
            checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL reject_err_%0d got=%b exp=1", t, cfg_err); end
            checks++; if (cfg_rdy !== 1'b1) begin failures++; $display("FAIL reject_rdy_%0d got=%b exp=1", t, cfg_rdy); end
            @(posedge clk); #1;
            checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reject_err_width_%0d got=%b exp=0", t, cfg_err); end
            do_request(vn[t], 10'd500, lat, pl, hl, vc, ec, ch, rl);
            checks++; if (vc != 0) begin failures++; $display("FAIL reject_vld_%0d got=%0d exp=0", t, vc); end
            checks++; if (ec != 1) begin failures++; $display("FAIL reject_err_count_%0d got=%0d exp=1", t, ec); end
            checks++; if (rl != 0) begin failures++; $display("FAIL reject_rdy_low_%0d got=%0d exp=0", t, rl); end
            checks++; if (period_limit !== 28'd99 || high_limit !== 28'd100) begin
                failures++; $display("FAIL reject_hold_%0d got=%0d/%0d exp=99/100", t, period_limit, high_limit);
            end
        end
    endtask

    // cfg_vld held on edges k+5..k+20 while busy is ignored.
    task automatic test_busy_ignore;
        int vc = 0, ec = 0, lat = -1;
        cfg_period = 28'd1000; cfg_duty = 10'd250; cfg_vld = 1'b1;
        @(posedge clk); #1;
        cfg_vld = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            if (i >= 5 && i <= 20) begin
                cfg_vld = 1'b1; cfg_period = 28'd500; cfg_duty = 10'd100;
            end else begin
                cfg_vld = 1'b0;
            end
            @(posedge clk); #1;
            if (cfg_err) ec++;
            if (para_config_vld) begin
                vc++;
                if (lat < 0) lat = i;
            end
        end
        cfg_vld = 1'b0;
        checks++; if (vc != 1) begin failures++; $display("FAIL busy_vld_count got=%0d exp=1", vc); end
        checks++; if (lat != 40) begin failures++; $display("FAIL busy_lat got=%0d exp=40", lat); end
        checks++; if (ec != 0) begin failures++; $display("FAIL busy_err got=%0d exp=0", ec); end
        checks++; if (period_limit !== 28'd999 || high_limit !== 28'd250) begin
            failures++; $display("FAIL busy_values got=%0d/%0d exp=999/250", period_limit, high_limit);
        end
    endtask

    // Continuous cfg_vld: strobes 41 cycles apart.
    task automatic test_back_to_back;
        int pulses [$];
        cfg_period = 28'd200; cfg_duty = 10'd500; cfg_vld = 1'b1;
        for (int i = 0; i <= 130; i++) begin
            @(posedge clk); #1;
            if (para_config_vld) pulses.push_back(i);
        end
        cfg_vld = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        checks++; if (pulses.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", pulses.size()); end
        for (int j = 0; j < 3 && j < pulses.size(); j++) begin
            checks++; if (pulses[j] != 40 + 41 * j) begin
                failures++; $display("FAIL b2b_pulse_%0d got=%0d exp=%0d", j, pulses[j], 40 + 41 * j);
            end
        end
        checks++; if (period_limit !== 28'd199 || high_limit !== 28'd100) begin
            failures++; $display("FAIL b2b_values got=%0d/%0d exp=199/100", period_limit, high_limit);
        end
    endtask

    // Reset during DIV aborts; the next request still computes correctly.
    task automatic test_reset_mid;
        int vc = 0, lat, ec, ch, rl;
        logic [27:0] pl, hl;
        cfg_period = 28'd1000; cfg_duty = 10'd500; cfg_vld = 1'b1;
        @(posedge clk); #1;
        cfg_vld = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (cfg_rdy !== 1'b1 || cfg_err !== 1'b0 || para_config_vld !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got=rdy%b err%b vld%b exp=rdy1 err0 vld0", cfg_rdy, cfg_err, para_config_vld);
        end
        checks++; if (period_limit !== 28'd0 || high_limit !== 28'd0) begin
            failures++; $display("FAIL midrst_values got=%0d/%0d exp=0/0", period_limit, high_limit);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (para_config_vld) vc++;
        end
        checks++; if (vc != 0) begin failures++; $display("FAIL midrst_no_vld got=%0d exp=0", vc); end
        do_request(28'd1000, 10'd500, lat, pl, hl, vc, ec, ch, rl);
        checks++; if (lat != 40 || pl !== 28'd999 || hl !== 28'd500) begin
            failures++; $display("FAIL midrst_next got=lat%0d %0d/%0d exp=lat40 999/500", lat, pl, hl);
        end
    endtask

    initial begin
        test_reset();
        test_compute();
        test_reject();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_param_calc.md
# pwm_param_calc

Configuration front-end for the PWM controller. It accepts a requested period (in clock cycles) and a duty cycle in permille, and computes the controller's period and high-time count thresholds with a sequential multiply/restoring-divide. It then presents them with a one-cycle `para_config_vld` strobe. It sits directly upstream of the PWM controller and drives that controller's `para_config_vld`, `period_limit` and `high_limit` inputs.

## Interface
- `CNT_W`, 28: width of period and threshold counts.
- `DUTY_W`, 10: width of the duty request.
- `DUTY_SCALE`, 1000: full-scale duty value (permille).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_vld`  in  1  request valid.
- `cfg_rdy`  out  1  block idle and able to accept a request.
- `cfg_period`  in  CNT_W  requested period N, in clk cycles.
- `cfg_duty`  in  DUTY_W  requested duty D, in permille.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.
- `para_config_vld`  out  1  one-cycle strobe: new thresholds are valid.
- `period_limit`  out  CNT_W  N-1.
- `high_limit`  out  CNT_W  floor(N*Dc/DUTY_SCALE).

## Operation
- **Request acceptance**
  - A request is accepted on a rising edge where `cfg_vld & cfg_rdy`.
  - `cfg_period` and `cfg_duty` are captured on that edge and need not be held afterwards.
- **Clamping and rejection**
  - Dc = min(D, DUTY_SCALE). Duty values above full scale clamp, with no error.
  - N < 2 is rejected: `cfg_err` pulses, no `para_config_vld`, outputs unchanged, and `cfg_rdy` stays high.
- **States:** IDLE → MUL → DIV → DONE → IDLE.
  - **IDLE:** `cfg_rdy`=1. A valid accepted request goes to MUL; a rejected request stays in IDLE.
  - **MUL:** register the product P = N*Dc (CNT_W+DUTY_W = 38 bits). One cycle, then DIV.
  - **DIV:** restoring division P / DUTY_SCALE, one quotient bit per cycle, CNT_W+DUTY_W iterations, MSB first.
    - The remainder register is wide enough for DUTY_SCALE plus 1 bit.
    - The quotient is truncated (floor). It is always ≤ N, so it fits in CNT_W.
  - **DONE:** load `period_limit` = N-1 and `high_limit` = quotient, pulse `para_config_vld`, then go to IDLE.
- **Boundary results**
  - Dc = 0 gives `high_limit` = 0.
  - Dc = DUTY_SCALE gives `high_limit` = N.
- **While busy**
  - `cfg_rdy`=0, and `cfg_vld` is ignored (not queued, no error).
- **Output hold**
  - Outputs hold their last computed values between updates.
  - `period_limit` and `high_limit` change only on the same edge that raises `para_config_vld`.
- **Reset**
  - Reset asserted at any time (including mid-DIV) aborts the computation and returns to IDLE.

## Timing
- **Reset values:**
  - `cfg_rdy` = 1
  - `cfg_err` = 0
  - `para_config_vld` = 0
  - `period_limit` = 0
  - `high_limit` = 0
  - Internal P, remainder, quotient and iteration counter = 0
- **Latency**
  - Accept on edge k → `para_config_vld` high during the cycle after edge k+CNT_W+DUTY_W+2 (k+40 at defaults). It is high for exactly one cycle.
  - `cfg_rdy` falls after edge k and rises after edge k+40, in the same cycle as `para_config_vld`.
  - A new request is therefore acceptable on edge k+41.
  - Throughput: one request per 41 cycles.
- **Rejection timing:** `cfg_err` is high in the cycle after the accepting edge. There is no state change.
- **Iteration counter:** counts 0..CNT_W+DUTY_W-1 and does not wrap; DIV exits at the terminal count.
- **Post-reset:** the first accept is possible on the first edge after `rst` deasserts.

## Structure
- **Package `pwm_pkg`:**
  - CNT_W, DUTY_W, DUTY_SCALE defaults.
  - State enum {IDLE, MUL, DIV, DONE}.
  - Derived constant PROD_W = CNT_W+DUTY_W.
- **Sub-module `pwm_div_seq`:**
  - Generic restoring divider with a start/done handshake.
  - Dividend width PROD_W; divisor is a constant parameter.
  - The parent FSM starts it from MUL and waits in DIV for done.
- **Top:** capture registers, clamp/reject logic, multiply register, FSM, output registers.

## Test plan
- N=1000, D=250 → 40 cycles after accept: `period_limit`=999, `high_limit`=250, single-cycle `para_config_vld`.
- N=3, D=500 → `high_limit`=1 (floor of 1.5), `period_limit`=2. N=0x0FFFFFFF, D=1000 → `high_limit`=0x0FFFFFFF (no overflow).
- D=0 with N=100 → `high_limit`=0. D=1023 with N=100 → clamped, `high_limit`=100, no `cfg_err`.
- N=1 or N=0 → `cfg_err` pulse, no `para_config_vld`, outputs retain previous values, `cfg_rdy` stays 1.
- Second `cfg_vld` held from cycle 5 to cycle 20 after an accept → ignored, only the first result is emitted. Holding `cfg_vld` continuously → accepts exactly every 41 cycles.
- Assert `rst` at cycle 20 of DIV → all outputs are at reset values immediately, `cfg_rdy`=1, and no `para_config_vld` follows. The next request computes correctly.
